// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: one load/store in flight, response after WAIT_CYCLES+1 cycles.
// Build option: define DMEM_MISALIGN_ERR_EN to fault accesses whose addr[1:0] != 0.
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [32:0] LIMIT    = 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          we_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   rdata_reg;
    logic          err_reg;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          complete;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic          acc_fault;
    logic          misalign;

    assign req_ready_o  = (state_reg == IDLE) && !rst_i;
    assign resp_valid_o = (state_reg == RESP);
    assign resp_rdata_o = rdata_reg;
    assign resp_err_o   = err_reg;
    assign busy_o       = (state_reg != IDLE);

    // With zero wait states the access happens on the acceptance edge,
    // before the request registers hold anything, so use the live inputs.
    always_comb begin
        acc_we    = we_reg;
        acc_addr  = addr_reg;
        acc_wdata = wdata_reg;
        if (state_reg == IDLE) begin
            acc_we    = req_we_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
        end
    end

    assign acc_idx = acc_addr[AW+1:2];

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = (acc_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign acc_fault = ({1'b0, acc_addr} >= LIMIT) || misalign;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        enter_resp = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= req_we_i;
                addr_reg  <= req_addr_i;
                wdata_reg <= req_wdata_i;
            end
            if (enter_resp) begin
                rdata_reg <= (acc_we || acc_fault) ? 32'd0 : mem[acc_idx];
                err_reg   <= acc_fault;
            end else if (complete) begin
                rdata_reg <= 32'd0;
                err_reg   <= 1'b0;
            end
        end
    end

    // Reset clears every word, so an interrupted store can never leave data behind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (enter_resp && acc_we && !acc_fault) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: drivers push expected responses, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DUT0: DEPTH=128, WAIT_CYCLES=2
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    // DUT1: DEPTH=4, WAIT_CYCLES=0
    logic        req_valid1 = 1'b0, req_we1 = 1'b0, resp_ready1 = 1'b0;
    logic [31:0] req_addr1 = 32'd0, req_wdata1 = 32'd0;
    logic        req_ready1, resp_valid1, resp_err1, busy1;
    logic [31:0] resp_rdata1;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc = 0, acc0 = 0, acc1 = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t cur0, cur1;
    logic seen0 = 1'b0, seen1 = 1'b0;

    data_mem_responder #(.DEPTH(128), .WAIT_CYCLES(2)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .busy_o(busy)
    );

    data_mem_responder #(.DEPTH(4), .WAIT_CYCLES(0)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_we_i(req_we1),
        .req_addr_i(req_addr1), .req_wdata_i(req_wdata1),
        .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready1),
        .resp_rdata_o(resp_rdata1), .resp_err_o(resp_err1), .busy_o(busy1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_checks++;
        n_fails++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Acceptance-edge timestamps for latency measurement.
    initial forever begin
        @(posedge clk);
        if (req_valid && req_ready)   acc0 = cyc;
        if (req_valid1 && req_ready1) acc1 = cyc;
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            seen0 = 1'b0;
        end else if (resp_valid && !seen0) begin
            seen0 = 1'b1;
            if (sb0.size() == 0) begin
                cur0 = '{rdata: 32'd0, err: 1'b0, lat: 0};
                flag("unexpected_resp0", $sformatf("response 0x%08h appeared, expected none", resp_rdata));
            end else begin
                cur0 = sb0.pop_front();
                check("rdata0", resp_rdata, cur0.rdata);
                check("err0", 32'(resp_err), 32'(cur0.err));
                check("latency0", 32'(cyc - acc0), 32'(cur0.lat));
                $display("dut0 resp rdata=0x%08h err=%0d latency=%0d", resp_rdata, resp_err, cyc - acc0);
            end
        end else if (resp_valid) begin
            check("hold_rdata0", resp_rdata, cur0.rdata);
            check("hold_err0", 32'(resp_err), 32'(cur0.err));
            check("hold_ready0", 32'(req_ready), 32'd0);
            check("hold_busy0", 32'(busy), 32'd1);
        end else if (seen0) begin
            seen0 = 1'b0;
            check("idle_rdata0", resp_rdata, 32'd0);
            check("idle_err0", 32'(resp_err), 32'd0);
            check("idle_ready0", 32'(req_ready), 32'd1);
            check("idle_busy0", 32'(busy), 32'd0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            seen1 = 1'b0;
        end else if (resp_valid1 && !seen1) begin
            seen1 = 1'b1;
            if (sb1.size() == 0) begin
                cur1 = '{rdata: 32'd0, err: 1'b0, lat: 0};
                flag("unexpected_resp1", $sformatf("response 0x%08h appeared, expected none", resp_rdata1));
            end else begin
                cur1 = sb1.pop_front();
                check("rdata1", resp_rdata1, cur1.rdata);
                check("err1", 32'(resp_err1), 32'(cur1.err));
                check("latency1", 32'(cyc - acc1), 32'(cur1.lat));
                $display("dut1 resp rdata=0x%08h err=%0d latency=%0d", resp_rdata1, resp_err1, cyc - acc1);
            end
        end else if (!resp_valid1 && seen1) begin
            seen1 = 1'b0;
            check("idle_rdata1", resp_rdata1, 32'd0);
            check("idle_ready1", 32'(req_ready1), 32'd1);
        end
    end

    // While waiting, valid stays high with junk store data: it must be ignored.
    task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int stall);
        exp_t e;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = 3;
        sb0.push_back(e);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            flag("accept_timeout0", "req_ready stayed 0, expected 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_addr  = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        req_wdata = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 30);
        if (!resp_valid) begin
            flag("resp_timeout0", "resp_valid stayed 0, expected 1");
            req_valid = 1'b0;
            return;
        end
        repeat (stall) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic txn1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = 1;
        sb1.push_back(e);
        @(negedge clk);
        req_valid1  = 1'b1;
        req_we1     = we;
        req_addr1   = addr;
        req_wdata1  = wdata;
        resp_ready1 = 1'b1;
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid1 && n < 30);
        if (!resp_valid1) begin
            flag("resp_timeout1", "resp_valid stayed 0, expected 1");
            return;
        end
        @(posedge clk);
        #1;
        resp_ready1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(req_ready), 32'd0);
        check("rst_busy0", 32'(busy), 32'd0);
        check("rst_valid0", 32'(resp_valid), 32'd0);
        check("rst_rdata0", resp_rdata, 32'd0);
        check("rst_err0", 32'(resp_err), 32'd0);
        check("rst_ready1", 32'(req_ready1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready0", 32'(req_ready), 32'd1);
        check("post_rst_ready1", 32'(req_ready1), 32'd1);

        txn0(1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, 0);
        txn0(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        txn0(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        txn0(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
        txn0(1'b1, 32'h0000_0200, 32'h0000_1234, 32'h0, 1'b1, 0);
        txn0(1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, 0);
        txn0(1'b0, 32'h0000_0200, 32'h0, 32'h0000_0000, 1'b1, 0);
        txn0(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 1'b1, 0);
        txn0(1'b1, 32'h0000_01FC, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
        txn0(1'b1, 32'h0000_0024, 32'h1111_1111, 32'h0, 1'b0, 0);
        txn0(1'b0, 32'h0000_01FC, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
        txn0(1'b0, 32'h0000_0024, 32'h0, 32'h1111_1111, 1'b0, 0);
`ifdef DMEM_MISALIGN_ERR_EN
        txn0(1'b1, 32'h0000_0013, 32'hA5A5_A5A5, 32'h0, 1'b1, 0);
        txn0(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
`else
        txn0(1'b1, 32'h0000_0013, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
        txn0(1'b0, 32'h0000_0010, 32'h0, 32'hA5A5_A5A5, 1'b0, 0);
`endif

        // Store to 0x20 interrupted by reset while in WAIT: no response, no write.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h0000_0020;
        req_wdata  = 32'h55AA_55AA;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("wait_busy0", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready0", 32'(req_ready), 32'd0);
        check("midrst_busy0", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        resp_ready = 1'b0;
        txn0(1'b0, 32'h0000_0020, 32'h0, 32'h0000_0000, 1'b0, 0);
        txn0(1'b0, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0, 0);

        txn1(1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0);
        txn1(1'b1, 32'h0000_0004, 32'h0000_0077, 32'h0, 1'b0);
        txn1(1'b1, 32'h0000_000C, 32'h8000_0001, 32'h0, 1'b0);
        txn1(1'b0, 32'h0000_0004, 32'h0, 32'h0000_0077, 1'b0);
        txn1(1'b0, 32'h0000_000C, 32'h0, 32'h8000_0001, 1'b0);
        txn1(1'b0, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b1);

        repeat (4) @(negedge clk);
        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
